// File: rtl/pingpong_ball_ctrl_if.sv
// Ping-pong ball controller bus: next-state input, new-game request and
// all game outputs grouped so the controller and its consumers share one bundle.
interface pingpong_ball_ctrl_if;
  logic [5:0] ns;
  logic       clr;
  logic [5:0] cs;
  logic [5:0] led;
  logic       tick;
  logic [3:0] score_l;
  logic [3:0] score_r;
  logic       game_over;
  logic       winner;

  // Master drives ns/clr and observes the game state.
  modport master (
    output ns, clr,
    input  cs, led, tick, score_l, score_r, game_over, winner
  );

  // Slave is the ball controller itself.
  modport slave (
    input  ns, clr,
    output cs, led, tick, score_l, score_r, game_over, winner
  );
endinterface

// File: rtl/pingpong_ball_ctrl.sv
// Ping-pong ball controller: game tick divider, current-state register fed back
// to the next-state logic, exit detection, scoring and winner declaration.
// Optional macro PINGPONG_POINT_FLASH_EN: flash all LEDs once per tick in POINT.
module pingpong_ball_ctrl #(
  parameter int unsigned TICK_DIV    = 12500000,
  parameter int unsigned POINT_TICKS = 4,
  parameter int unsigned WIN_SCORE   = 7
) (
  input logic                 clk,
  input logic                 rst_n,
  pingpong_ball_ctrl_if.slave bus
);

  localparam int unsigned TickW  = $clog2(TICK_DIV);
  localparam int unsigned PointW = $clog2(POINT_TICKS + 1);
  localparam logic [TickW-1:0]  TickLast  = TickW'(TICK_DIV - 1);
  localparam logic [PointW-1:0] PointLast = PointW'(POINT_TICKS - 1);
  localparam logic [3:0]        WinScore  = 4'(WIN_SCORE);

  typedef enum logic [1:0] {StRun, StPoint, StOver} state_e;

  state_e              state_q, state_d;
  logic [TickW-1:0]    cnt_q, cnt_d;
  logic                tick_q, tick_d;
  logic [PointW-1:0]   pt_q, pt_d;
  logic [5:0]          cs_q, cs_d;
  logic [3:0]          score_l_q, score_l_d;
  logic [3:0]          score_r_q, score_r_d;
  logic                game_over_q, game_over_d;
  logic                winner_q, winner_d;
  logic [5:0]          point_led;

  // Free-running tick divider; tick_q is high while the counter sits at its last value.
  always_comb begin
    cnt_d  = (cnt_q == TickLast) ? '0 : cnt_q + 1'b1;
    tick_d = (cnt_d == TickLast);
  end

  // Game FSM next-state, scoring and current-state load; clr overrides everything.
  always_comb begin
    state_d     = state_q;
    pt_d        = pt_q;
    cs_d        = cs_q;
    score_l_d   = score_l_q;
    score_r_d   = score_r_q;
    game_over_d = game_over_q;
    winner_d    = winner_q;
    case (state_q)
      StRun: begin
        if (tick_q) begin
          cs_d = bus.ns;
          if (cs_q == 6'b000001 && bus.ns == 6'b000000) begin
            score_l_d = score_l_q + 4'd1;
            if (score_l_d == WinScore) begin
              state_d     = StOver;
              game_over_d = 1'b1;
              winner_d    = 1'b1;
            end else begin
              state_d = StPoint;
              pt_d    = '0;
            end
          end else if (cs_q == 6'b100000 && bus.ns == 6'b000000) begin
            score_r_d = score_r_q + 4'd1;
            if (score_r_d == WinScore) begin
              state_d     = StOver;
              game_over_d = 1'b1;
              winner_d    = 1'b0;
            end else begin
              state_d = StPoint;
              pt_d    = '0;
            end
          end
        end
      end
      StPoint: begin
        cs_d = '0;
        if (tick_q) begin
          if (pt_q == PointLast) begin
            state_d = StRun;
          end else begin
            pt_d = pt_q + 1'b1;
          end
        end
      end
      StOver: begin
        cs_d = '0;
      end
      default: begin
        state_d = StRun;
        cs_d    = '0;
      end
    endcase
    if (bus.clr) begin
      state_d     = StRun;
      pt_d        = '0;
      cs_d        = '0;
      score_l_d   = '0;
      score_r_d   = '0;
      game_over_d = 1'b0;
      winner_d    = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StRun;
      cnt_q       <= '0;
      tick_q      <= 1'b0;
      pt_q        <= '0;
      cs_q        <= '0;
      score_l_q   <= '0;
      score_r_q   <= '0;
      game_over_q <= 1'b0;
      winner_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tick_q      <= tick_d;
      pt_q        <= pt_d;
      cs_q        <= cs_d;
      score_l_q   <= score_l_d;
      score_r_q   <= score_r_d;
      game_over_q <= game_over_d;
      winner_q    <= winner_d;
    end
  end

`ifdef PINGPONG_POINT_FLASH_EN
  logic flash_q, flash_d;

  // Flash phase: lit on POINT entry, toggled on every tick while in POINT.
  always_comb begin
    flash_d = flash_q;
    if (bus.clr) begin
      flash_d = 1'b0;
    end else if (state_q != StPoint && state_d == StPoint) begin
      flash_d = 1'b1;
    end else if (state_q == StPoint && tick_q) begin
      flash_d = ~flash_q;
    end
  end

  // Flash phase register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flash_q <= 1'b0;
    end else begin
      flash_q <= flash_d;
    end
  end

  assign point_led = {6{flash_q}};
`else
  assign point_led = 6'b000000;
`endif

  // LED decode from registered state.
  always_comb begin
    bus.led = 6'b000000;
    case (state_q)
      StRun:   bus.led = cs_q;
      StPoint: bus.led = point_led;
      StOver:  bus.led = winner_q ? 6'b111000 : 6'b000111;
      default: bus.led = 6'b000000;
    endcase
  end

  assign bus.cs        = cs_q;
  assign bus.tick      = tick_q;
  assign bus.score_l   = score_l_q;
  assign bus.score_r   = score_r_q;
  assign bus.game_over = game_over_q;
  assign bus.winner    = winner_q;

endmodule
